// File: rtl/price_bin2bcd_pkg.sv
// Shared vending types/constants for the price binary-to-BCD path.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
// Contents: state_e (IDLE/SHIFT/DONE), PRICE_W, PRICE_DIGITS, digits_needed().
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int PRICE_W      = 8;
  localparam int PRICE_DIGITS = 3;

  // Decimal digits needed to show the largest WIDTH-bit value (2^width - 1).
  function automatic int digits_needed(input int width);
    longint unsigned max_v;
    int              n;
    max_v = (64'd1 << width) - 64'd1;
    n     = 1;
    while (max_v > 64'd9) begin
      max_v = max_v / 64'd10;
      n     = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/price_bin2bcd_if.sv
// Start/busy/done conversion bus between a price source and the BCD converter.
// Latency: n/a (wiring only).
// Backpressure: none; start is dropped by the converter while busy.
// Ports: master drives start/bin_in and observes bcd_out/busy/done; slave is the converter.
interface price_bin2bcd_if
  import vend_pkg::*;
#(
  parameter int WIDTH  = PRICE_W,
  parameter int DIGITS = PRICE_DIGITS
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  busy;
  logic                  done;

  modport master (output start, bin_in, input bcd_out, busy, done);
  modport slave  (input start, bin_in, output bcd_out, busy, done);
endinterface

// File: rtl/price_bin2bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5..9 before the shift.
// Latency: combinational.
// Backpressure: n/a.
// Ports: din = scratch digit before the shift, dout = corrected digit.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? (din + 4'd3) : din;
endmodule

// File: rtl/price_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) for price display.
// Latency: start accepted at edge E -> done pulse and new bcd_out after edge E+WIDTH+1.
// Backpressure: start is ignored while busy; a start in the DONE cycle restarts back-to-back.
// Ports: clk, rst (sync, active high), bus (slave): start/bin_in in, bcd_out/busy/done out.
module price_bin2bcd
  import vend_pkg::*;
#(
  parameter int WIDTH  = PRICE_W,
  parameter int DIGITS = PRICE_DIGITS
) (
  input  logic            clk,
  input  logic            rst,
  price_bin2bcd_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int SCR_W = 4 * DIGITS;

  // Refuse to build a converter whose output cannot hold the largest input.
  if (DIGITS < digits_needed(WIDTH)) begin : g_width_check
    $error("price_bin2bcd: DIGITS too small for WIDTH");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   bin_q,   bin_d;
  logic [SCR_W-1:0]   scr_q,   scr_d;
  logic [SCR_W-1:0]   scr_adj;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [SCR_W-1:0]   bcd_q,   bcd_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (scr_q[4*g +: 4]),
      .dout (scr_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          bin_d   = bus.bin_in;
          scr_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Corrected digits and remaining binary bits shift as one register.
        {scr_d, bin_d} = {scr_adj, bin_q} << 1;
        cnt_d          = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d  = scr_q;
        done_d = 1'b1;
        if (bus.start) begin
          bin_d   = bus.bin_in;
          scr_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // On a back-to-back restart busy rises one cycle after the done pulse,
    // so the two flags are never seen high together.
    busy_d = (state_d == SHIFT) && !done_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.bcd_out = bcd_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_price_bin2bcd.sv
// Self-checking bench for price_bin2bcd: directed vectors plus a full 8-bit sweep.
// Expected BCD values are queued at stimulus time; a monitor pops them on every done.
// Also checks latency, busy length, done width, ignored starts, reset abort, back-to-back.
module tb_price_bin2bcd;
  import vend_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  price_bin2bcd_if #(.WIDTH(PRICE_W), .DIGITS(PRICE_DIGITS)) bus ();

  price_bin2bcd #(.WIDTH(PRICE_W), .DIGITS(PRICE_DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int done_cnt = 0;
  logic [11:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Scoreboard monitor: every done must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    logic [11:0] e;
    if (!rst && bus.done) begin
      done_cnt++;
      check("busy_with_done", 32'(bus.busy), 32'd0);
      for (int d = 0; d < 3; d++) begin
        check("digit_range", 32'(bus.bcd_out[4*d +: 4] <= 4'd9), 32'd1);
      end
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done with bcd_out %h, expected no done", bus.bcd_out);
      end else begin
        e = exp_q.pop_front();
        check("bcd_out", 32'(bus.bcd_out), 32'(e));
      end
    end
  end

  // Waits for done on the next negedges; returns the cycle stamp (or -1) and busy count.
  task automatic wait_done(output int at, output int nbusy);
    at    = -1;
    nbusy = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (bus.done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: got no done within 30 cycles, expected a done pulse");
    end
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic convert(input logic [7:0] v, input logic [11:0] e, input int gap);
    int acc, at, nb;
    bus.start  = 1'b1;
    bus.bin_in = v;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.bin_in = 8'($urandom);
    acc        = cyc;
    wait_done(at, nb);
    if (at >= 0) begin
      check("latency", 32'(at - acc), 32'd9);
      check("busy_cycles", 32'(nb), 32'd8);
      @(negedge clk);
      check("done_width", 32'(bus.done), 32'd0);
    end
    repeat (gap) @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no end of test, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int acc, acc2, at, at2, nb, saved;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    rst        = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_bcd", 32'(bus.bcd_out), 32'h000);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    convert(8'd0,   12'h000, 1);
    convert(8'd15,  12'h015, 0);
    convert(8'd99,  12'h099, 2);
    convert(8'd255, 12'h255, 0);

    // Second start during the conversion must be dropped.
    bus.start  = 1'b1;
    bus.bin_in = 8'd200;
    exp_q.push_back(12'h200);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    acc       = cyc;
    repeat (2) @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.bin_in = 8'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(at, nb);
    if (at >= 0) check("ignore_latency", 32'(at - acc), 32'd9);
    repeat (12) @(negedge clk);
    check("hold_after_ignore", 32'(bus.bcd_out), 32'h200);

    // Reset in the middle of a conversion aborts it without a done.
    saved      = done_cnt;
    bus.start  = 1'b1;
    bus.bin_in = 8'd123;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_bcd", 32'(bus.bcd_out), 32'h000);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    repeat (15) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(saved));
    convert(8'd45, 12'h045, 0);

    // Back-to-back: start held, new value presented in the DONE cycle.
    bus.start  = 1'b1;
    bus.bin_in = 8'd10;
    exp_q.push_back(12'h010);
    exp_q.push_back(12'h250);
    @(posedge clk);
    #1;
    acc = cyc;
    repeat (8) @(posedge clk);
    #1;
    bus.bin_in = 8'd250;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    acc2      = cyc;
    wait_done(at, nb);
    if (at >= 0) check("b2b_first_latency", 32'(at - acc), 32'd9);
    wait_done(at2, nb);
    if (at2 >= 0) check("b2b_second_latency", 32'(at2 - acc2), 32'd9);
    if (at >= 0 && at2 >= 0) check("b2b_spacing", 32'(at2 - at), 32'd9);
    repeat (3) @(negedge clk);

    for (int v = 0; v < 256; v++) begin
      convert(8'(v), ref_bcd(v), int'($urandom_range(0, 3)));
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
